// File: rtl/imem_responder.sv
// Dual-slot instruction memory responder: two read ports, one program-load
// write port, fixed-latency response pipeline with flush and per-slot faults.
module imem_responder #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     imem_ren,
  input  logic [XLEN-1:0]          imem_addr0,
  input  logic [XLEN-1:0]          imem_addr1,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [XLEN-1:0]          prog_wdata,
  output logic                     imem_valid,
  output logic [XLEN-1:0]          imem_rdata0,
  output logic [XLEN-1:0]          imem_rdata1,
  output logic [XLEN-1:0]          imem_pc0,
  output logic [XLEN-1:0]          imem_pc1,
  output logic [1:0]               imem_fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] rdata0;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] pc0;
    logic [XLEN-1:0] pc1;
    logic [1:0]      fault;
  } rsp_t;

  logic [31:0]        mem_q [DEPTH];
  logic [AW-1:0]      idx0, idx1;
  logic               flt0, flt1;
  rsp_t               rsp_d;
  logic [LATENCY-1:0] vld_q;
  rsp_t               stg_q [LATENCY];

  assign idx0 = imem_addr0[AW+1:2];
  assign idx1 = imem_addr1[AW+1:2];

  // Misaligned, or any address bit above the array span set.
  assign flt0 = (imem_addr0[1:0] != 2'b00) || (|imem_addr0[XLEN-1:AW+2]);
  assign flt1 = (imem_addr1[1:0] != 2'b00) || (|imem_addr1[XLEN-1:AW+2]);

  always_comb begin
    rsp_d        = '0;
    rsp_d.rdata0 = flt0 ? XLEN'(NOP_WORD) : XLEN'(mem_q[idx0]);
    rsp_d.rdata1 = flt1 ? XLEN'(NOP_WORD) : XLEN'(mem_q[idx1]);
    rsp_d.pc0    = imem_addr0;
    rsp_d.pc1    = imem_addr1;
    rsp_d.fault  = {flt1, flt0};
  end

  // Array read happens before this edge's write lands, giving old data on a collision.
  always_ff @(posedge clk) begin
    if (!reset && prog_we) begin
      mem_q[prog_addr] <= prog_wdata[31:0];
    end
  end

  // Stage 0 always accepts (flush only squashes older stages); payload moves
  // only with a valid bit so the output stage holds its last response.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= imem_ren;
      if (imem_ren) begin
        stg_q[0] <= rsp_d;
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1] & ~flush;
        if (vld_q[k-1] && !flush) begin
          stg_q[k] <= stg_q[k-1];
        end
      end
    end
  end

  assign imem_valid  = vld_q[LATENCY-1];
  assign imem_rdata0 = stg_q[LATENCY-1].rdata0;
  assign imem_rdata1 = stg_q[LATENCY-1].rdata1;
  assign imem_pc0    = stg_q[LATENCY-1].pc0;
  assign imem_pc1    = stg_q[LATENCY-1].pc1;
  assign imem_fault  = stg_q[LATENCY-1].fault;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 1, 2, 3) share
// one stimulus stream; each scenario checks the instance it targets.
module tb_imem_responder;

  logic        clk;
  logic        reset;
  logic        imem_ren;
  logic [31:0] imem_addr0, imem_addr1;
  logic        flush;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_wdata;

  logic        v1, v2, v3;
  logic [31:0] r0_1, r1_1, p0_1, p1_1;
  logic [31:0] r0_2, r1_2, p0_2, p1_2;
  logic [31:0] r0_3, r1_3, p0_3, p1_3;
  logic [1:0]  f_1, f_2, f_3;

  int n_checks = 0;
  int n_fail   = 0;

  imem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
    .imem_addr1(imem_addr1), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .imem_valid(v1), .imem_rdata0(r0_1), .imem_rdata1(r1_1),
    .imem_pc0(p0_1), .imem_pc1(p1_1), .imem_fault(f_1));

  imem_responder #(.LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
    .imem_addr1(imem_addr1), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .imem_valid(v2), .imem_rdata0(r0_2), .imem_rdata1(r1_2),
    .imem_pc0(p0_2), .imem_pc1(p1_2), .imem_fault(f_2));

  imem_responder #(.LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
    .imem_addr1(imem_addr1), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .imem_valid(v3), .imem_rdata0(r0_3), .imem_rdata1(r1_3),
    .imem_pc0(p0_3), .imem_pc1(p1_3), .imem_fault(f_3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_val(input int i);
    return 32'h11111111 * (i + 1);
  endfunction

  task automatic req(input logic [31:0] a0, input logic [31:0] a1);
    imem_ren   = 1'b1;
    imem_addr0 = a0;
    imem_addr1 = a1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL reset_v1: got %b want 0", v1); end
    n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL reset_v2: got %b want 0", v2); end
    n_checks++; if (v3 !== 1'b0) begin n_fail++; $display("FAIL reset_v3: got %b want 0", v3); end
    n_checks++; if ({r0_1, r1_1, p0_1, p1_1} !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", r0_1, r1_1, p0_1, p1_1); end
    n_checks++; if (f_1 !== 2'b00) begin n_fail++; $display("FAIL reset_fault: got %b want 00", f_1); end
    reset = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < 8; i++) begin
      prog_we    = 1'b1;
      prog_addr  = 8'(i);
      prog_wdata = word_val(i);
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic test_basic();
    req(32'h00, 32'h04);
    tick();
    imem_ren = 1'b0;
    n_checks++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", v1); end
    n_checks++; if (r0_1 !== 32'h11111111) begin n_fail++; $display("FAIL basic_rdata0: got %h want 11111111", r0_1); end
    n_checks++; if (r1_1 !== 32'h22222222) begin n_fail++; $display("FAIL basic_rdata1: got %h want 22222222", r1_1); end
    n_checks++; if (p0_1 !== 32'h00 || p1_1 !== 32'h04) begin n_fail++; $display("FAIL basic_pc: got %h/%h want 0/4", p0_1, p1_1); end
    n_checks++; if (f_1 !== 2'b00) begin n_fail++; $display("FAIL basic_fault: got %b want 00", f_1); end
    tick();
    n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b want 0", v1); end
    n_checks++; if (r0_1 !== 32'h11111111 || p1_1 !== 32'h04) begin n_fail++; $display("FAIL basic_hold: got %h/%h want 11111111/4", r0_1, p1_1); end
  endtask

  task automatic test_same_word();
    req(32'h14, 32'h14);
    tick();
    imem_ren = 1'b0;
    n_checks++; if (r0_1 !== 32'h66666666 || r1_1 !== 32'h66666666) begin n_fail++; $display("FAIL same_word: got %h/%h want 66666666/66666666", r0_1, r1_1); end
  endtask

  task automatic test_fault();
    req(32'h06, 32'h400);
    tick();
    n_checks++; if (f_1 !== 2'b11) begin n_fail++; $display("FAIL fault_flags: got %b want 11", f_1); end
    n_checks++; if (r0_1 !== 32'h13 || r1_1 !== 32'h13) begin n_fail++; $display("FAIL fault_nop: got %h/%h want 13/13", r0_1, r1_1); end
    n_checks++; if (p0_1 !== 32'h06 || p1_1 !== 32'h400) begin n_fail++; $display("FAIL fault_pc: got %h/%h want 6/400", p0_1, p1_1); end
    req(32'h08, 32'h3FC);
    tick();
    n_checks++; if (f_1 !== 2'b00 || r1_1 !== 32'h0 + r1_1 || r0_1 !== 32'h33333333) begin n_fail++; $display("FAIL top_word: got %b %h want 00 33333333", f_1, r0_1); end
    req(32'h09, 32'h0C);
    tick();
    imem_ren = 1'b0;
    n_checks++; if (f_1 !== 2'b01) begin n_fail++; $display("FAIL mixed_fault: got %b want 01", f_1); end
    n_checks++; if (r0_1 !== 32'h13 || r1_1 !== 32'h44444444) begin n_fail++; $display("FAIL mixed_data: got %h/%h want 13/44444444", r0_1, r1_1); end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 7; t++) begin
      if (t < 4) req(32'(t * 8), 32'(t * 8 + 4));
      else imem_ren = 1'b0;
      tick();
      if (t >= 2 && t <= 5) begin
        n_checks++; if (v3 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: got %b want 1", t, v3); end
        n_checks++;
        if (r0_3 !== word_val((t - 2) * 2) || r1_3 !== word_val((t - 2) * 2 + 1) || p0_3 !== 32'((t - 2) * 8)) begin
          n_fail++; $display("FAIL b2b_data_%0d: got %h/%h pc %h want %h/%h pc %h", t, r0_3, r1_3, p0_3,
                              word_val((t - 2) * 2), word_val((t - 2) * 2 + 1), 32'((t - 2) * 8));
        end
      end else begin
        n_checks++; if (v3 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d: got %b want 0", t, v3); end
      end
    end
  endtask

  task automatic test_flush();
    req(32'h00, 32'h04);
    tick();
    flush = 1'b1;
    req(32'h08, 32'h0C);
    tick();
    flush    = 1'b0;
    imem_ren = 1'b0;
    n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL flush_squash: got %b want 0", v2); end
    tick();
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL flush_new_valid: got %b want 1", v2); end
    n_checks++; if (r0_2 !== 32'h33333333 || p0_2 !== 32'h08) begin n_fail++; $display("FAIL flush_new_data: got %h pc %h want 33333333 pc 8", r0_2, p0_2); end
    tick();
    n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL flush_pulse: got %b want 0", v2); end
  endtask

  task automatic test_read_before_write();
    prog_we    = 1'b1;
    prog_addr  = 8'd2;
    prog_wdata = 32'hDEADBEEF;
    req(32'h08, 32'h08);
    tick();
    prog_we = 1'b0;
    n_checks++; if (r0_1 !== 32'h33333333 || r1_1 !== 32'h33333333) begin n_fail++; $display("FAIL rbw_old: got %h/%h want 33333333", r0_1, r1_1); end
    tick();
    imem_ren = 1'b0;
    n_checks++; if (r0_1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rbw_new: got %h want deadbeef", r0_1); end
    tick();
    n_checks++; if (v3 !== 1'b1 || r0_3 !== 32'h33333333) begin n_fail++; $display("FAIL inflight_old: got %b %h want 1 33333333", v3, r0_3); end
    tick();
    n_checks++; if (v3 !== 1'b1 || r0_3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL inflight_new: got %b %h want 1 deadbeef", v3, r0_3); end
  endtask

  task automatic test_reset_mid();
    req(32'h10, 32'h14);
    tick();
    reset      = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = 8'd4;
    prog_wdata = 32'hBADBAD00;
    tick();
    n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_v_a: got %b want 0", v2); end
    n_checks++; if (r0_1 !== 32'h0 || f_1 !== 2'b00) begin n_fail++; $display("FAIL rstmid_clear: got %h %b want 0 00", r0_1, f_1); end
    tick();
    n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_v_b: got %b want 0", v2); end
    reset    = 1'b0;
    prog_we  = 1'b0;
    imem_ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (v2 !== 1'b0 || v3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_%0d: got %b/%b want 0/0", i, v2, v3); end
    end
    req(32'h10, 32'h14);
    tick();
    imem_ren = 1'b0;
    tick();
    n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL rstmid_reread_v: got %b want 1", v2); end
    n_checks++; if (r0_2 !== 32'h55555555 || r1_2 !== 32'h66666666) begin n_fail++; $display("FAIL rstmid_preserved: got %h/%h want 55555555/66666666", r0_2, r1_2); end
  endtask

  initial begin
    reset      = 1'b1;
    imem_ren   = 1'b0;
    imem_addr0 = '0;
    imem_addr1 = '0;
    flush      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    test_reset();
    load_program();
    test_basic();
    test_same_word();
    test_fault();
    tick(); tick(); tick();
    test_back_to_back();
    tick(); tick(); tick();
    test_flush();
    tick(); tick(); tick();
    test_read_before_write();
    tick(); tick(); tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter DEPTH, default 256, number of 32-bit words; power of two.
REQ-003 Parameter LATENCY, default 1, request-to-response cycles; legal range 1..4.
REQ-004 Parameter NOP_WORD, default 32'h00000013, substitute data for faulting slots.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 imem_ren  input  1  fetch read request; both slots are requested together.
REQ-008 imem_addr0  input  XLEN  slot-0 byte address.
REQ-009 imem_addr1  input  XLEN  slot-1 byte address.
REQ-010 flush  input  1  squash all in-flight responses (redirect).
REQ-011 prog_we  input  1  program-load write enable.
REQ-012 prog_addr  input  log2(DEPTH)  program-load word index.
REQ-013 prog_wdata  input  XLEN  program-load data.
REQ-014 imem_valid  output  1  response valid, one-cycle pulse per accepted request.
REQ-015 imem_rdata0  output  XLEN  slot-0 instruction.
REQ-016 imem_rdata1  output  XLEN  slot-1 instruction.
REQ-017 imem_pc0  output  XLEN  slot-0 echoed request address.
REQ-018 imem_pc1  output  XLEN  slot-1 echoed request address.
REQ-019 imem_fault  output  2  per-slot fault flag, bit i for slot i.

Function
REQ-020 Storage SHALL be a DEPTH x 32 array with two independent read ports and one write port.
REQ-021 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-022 A request SHALL be accepted in every cycle where imem_ren=1 and reset=0; no backpressure exists.
REQ-023 An accepted request SHALL produce imem_valid=1 exactly LATENCY cycles after the accepting edge, with data, echoed PCs and fault flags for that request.
REQ-024 The response pipeline SHALL be LATENCY stages deep; back-to-back requests SHALL produce back-to-back responses in order, one per cycle.
REQ-025 Slot i SHALL fault when addr_i[1:0] != 0 or addr_i >= DEPTH*4; a faulting slot SHALL return NOP_WORD with imem_fault[i]=1 and still echo its PC.
REQ-026 Slot faults SHALL be independent; a fault in one slot SHALL NOT alter the other slot's data.
REQ-027 Both slots addressing the same word SHALL return identical data.
REQ-028 When imem_valid=0, rdata, pc and fault outputs SHALL hold their last driven values.
REQ-029 flush=1 SHALL clear the valid bit of every in-flight stage at that edge, so no response from a request accepted before the flush cycle appears.
REQ-030 A request with imem_ren=1 in the same cycle as flush=1 SHALL be accepted and answered normally.
REQ-031 prog_we=1 SHALL write prog_wdata to prog_addr at the rising edge.
REQ-032 A read and a write to the same word in one cycle SHALL return the old data (read-before-write).
REQ-033 A write SHALL be visible to any read accepted on a later cycle.
REQ-034 With LATENCY>1, data SHALL be sampled from the array at acceptance; a later write SHALL NOT change an in-flight response.

Reset
REQ-035 During reset, imem_valid SHALL be 0, all pipeline valid bits SHALL be cleared, and rdata0/1, pc0/1 and imem_fault SHALL be 0.
REQ-036 Requests and writes presented while reset=1 SHALL be ignored.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight responses; no valid response is produced for them after release.
REQ-038 Array contents SHALL NOT be cleared by reset.

Verification
REQ-039 LATENCY=1, words 0..5 = 0x11111111..0x66666666; ren with addr 0x00/0x04 -> next cycle valid=1, rdata 0x11111111/0x22222222, pc 0x00/0x04, fault 2'b00.
REQ-040 LATENCY=3, ren for four consecutive cycles at 0x00,0x08,0x10,0x18 pairs -> four consecutive valid pulses starting 3 cycles later, in order.
REQ-041 addr0=0x06, addr1=0x400 (DEPTH=256) -> fault=2'b11, both rdata 0x00000013, pc 0x06/0x400.
REQ-042 LATENCY=2, ren at cycle N, flush at N+1 with ren at 0x08 -> no response for cycle N; response for 0x08 at N+3 with 0x33333333.
REQ-043 prog_we writing 0xDEADBEEF to word 2 while ren reads 0x08 -> old 0x33333333 returned; read of 0x08 next cycle returns 0xDEADBEEF.
REQ-044 reset asserted one cycle after ren with LATENCY=2 -> imem_valid stays 0 through and after reset; memory contents preserved.
